stream_rsp_router: RTL and testbench
====================================

Name: stream_rsp_router

Overview:
- Downstream companion of the N:1 stream arbiter. It records the arbiter's per-grant select index in order, then steers the in-order response stream back to the requester that issued each request.
- Sits between the shared memory/unit response port and the NUM_INPUTS requester response ports.
- Provides outstanding-request tracking, back-pressure, and a registered output stage.

Parameters:
- NUM_INPUTS, 4, number of requesters (equals the arbiter's NUM_REQS); ≥2.
- DATAW, 32, response payload width.
- TAG_DEPTH, 8, maximum outstanding requests; power of two, ≥2.
- SEL_W, `UP(`CLOG2(NUM_INPUTS)), select index width.
- CNT_W, `CLOG2(TAG_DEPTH+1), occupancy counter width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- push_valid  in  1  a request left the arbiter (valid_out && ready_out).
- push_sel  in  SEL_W  arbiter sel_out for that request.
- push_ready  out  1  tracker can accept an entry; upstream must stall the arbiter when low.
- rsp_valid_in  in  1  shared response valid.
- rsp_data_in  in  DATAW  shared response payload.
- rsp_ready_in  out  1  shared response accepted.
- rsp_valid_out  out  NUM_INPUTS  per-requester response valid.
- rsp_data_out  out  NUM_INPUTS*DATAW  per-requester payload; same register broadcast to all lanes.
- rsp_ready_out  in  NUM_INPUTS  per-requester ready.
- pending  out  CNT_W  entries in the tag FIFO.
- sel_err  out  1  sticky: a response was routed with select ≥ NUM_INPUTS.

Behaviour:
- Reset (reset=0, async):
  - FIFO pointers, pending, sel_err, out_valid_q, out_sel_q, out_data_q all clear to 0.
  - Resulting outputs: push_ready=1, rsp_ready_in=0, rsp_valid_out=0, rsp_data_out=0.
  - A reset mid-operation discards all outstanding entries and any held output. A response in flight is lost.
- Tag FIFO:
  - TAG_DEPTH entries of SEL_W bits, with wrap-around read/write pointers plus one extra wrap bit each.
  - full: pointers equal except the wrap bit. empty: pointers equal.
- Push rules:
  - push_ready = !full. A push fires on push_valid && push_ready.
  - No bypass when full: a push is refused even if a pop happens in the same cycle.
  - push_valid while push_ready=0 is a protocol violation. It is ignored and leaves state unchanged.
- Output stage:
  - A single register holds out_valid_q, out_sel_q and out_data_q.
  - rsp_valid_out[i] = out_valid_q && (out_sel_q == i).
  - out_drain = out_valid_q && rsp_ready_out[out_sel_q].
- Response accept:
  - rsp_ready_in = !empty && (!out_valid_q || out_drain). This gives full-throughput pipelining, one response per cycle.
  - On rsp fire, the head of the tag FIFO is popped and loaded into the register (out_sel_q ← head, out_data_q ← rsp_data_in, out_valid_q ← 1).
  - On out_drain without a new fire, out_valid_q ← 0.
- Latency: rsp_in fire at cycle t → rsp_valid_out valid at t+1.
- Empty FIFO: rsp_ready_in=0, so a response with no outstanding tag is never accepted.
  - A push and a rsp_valid_in in the same cycle while empty: the push is accepted, the rsp is accepted next cycle at the earliest (no FIFO bypass).
- Out-of-range select (head ≥ NUM_INPUTS):
  - The response is still popped and consumed, but out_valid_q stays 0 for it, so it is dropped.
  - sel_err ← 1, cleared only by reset.
- pending:
  - +1 on push only, −1 on pop only, unchanged on both or neither.
  - Range 0..TAG_DEPTH.
- Order: responses are delivered strictly in push order, regardless of requester.
- Data not qualified by valid holds its last value (no zeroing).

Test Plan:
- Reset then idle → push_ready=1, rsp_ready_in=0, pending=0, rsp_valid_out=0000; assert reset mid-stream with pending=5 → all outputs return to reset values immediately (async).
- Push sels 2,0,3,1, then responses D0..D3 with all rsp_ready_out=1 → lanes 2,0,3,1 each receive their Dk one cycle after accept; one per cycle; pending 4→0.
- Fill 8 pushes (TAG_DEPTH=8) → push_ready=0 at pending=8; a push+pop in the same cycle → push refused, pending=7, push_ready=1 next cycle.
- Push sel 1, sel 1; response A, B with rsp_ready_out[1] low for 3 cycles → A held stable on lane 1, rsp_ready_in=0 while held; B delivered in the cycle after A drains.
- Empty FIFO with rsp_valid_in=1 plus a simultaneous push of sel 3 → rsp_ready_in=0 that cycle, accepted next cycle, lane 3 valid one cycle later.
- NUM_INPUTS=3, push sel 3 then sel 0; two responses → first dropped, sel_err=1, no lane valid; second delivered on lane 0; sel_err stays 1.

Source files
------------

// File: rtl/stream_rsp_router.sv
// Routes an in-order shared response stream back to the requester that issued
// each request, using a FIFO of arbiter select indices captured at grant time.
module stream_rsp_router #(
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned DATAW      = 32,
    parameter int unsigned TAG_DEPTH  = 8,
    localparam int unsigned SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    localparam int unsigned CNT_W     = $clog2(TAG_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_valid,
    input  logic [SEL_W-1:0]            push_sel,
    output logic                        push_ready,
    input  logic                        rsp_valid_in,
    input  logic [DATAW-1:0]            rsp_data_in,
    output logic                        rsp_ready_in,
    output logic [NUM_INPUTS-1:0]       rsp_valid_out,
    output logic [NUM_INPUTS*DATAW-1:0] rsp_data_out,
    input  logic [NUM_INPUTS-1:0]       rsp_ready_out,
    output logic [CNT_W-1:0]            pending,
    output logic                        sel_err
);

    localparam int unsigned AW    = $clog2(TAG_DEPTH);
    localparam int unsigned PTR_W = AW + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pending_q, pending_d;
    logic             sel_err_q, sel_err_d;
    logic             out_valid_q, out_valid_d;
    logic [SEL_W-1:0] out_sel_q, out_sel_d;
    logic [DATAW-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] tag_mem_q [TAG_DEPTH];

    logic             full, empty, push_fire, rsp_fire, out_drain, sel_ready;
    logic             head_in_range;
    logic [SEL_W-1:0] head;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty         = (wr_ptr_q == rd_ptr_q);
    assign full          = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head          = tag_mem_q[rd_ptr_q[AW-1:0]];
    assign head_in_range = 32'(head) < NUM_INPUTS;

    assign push_ready   = !full;
    assign push_fire    = push_valid && !full;
    assign out_drain    = out_valid_q && sel_ready;
    assign rsp_ready_in = !empty && (!out_valid_q || out_drain);
    assign rsp_fire     = rsp_valid_in && rsp_ready_in;

    assign pending      = pending_q;
    assign sel_err      = sel_err_q;
    assign rsp_data_out = {NUM_INPUTS{out_data_q}};

    // Lane decode of the held response and the ready of its target lane.
    always_comb begin
        sel_ready     = 1'b0;
        rsp_valid_out = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (out_sel_q == SEL_W'(i)) begin
                sel_ready        = rsp_ready_out[i];
                rsp_valid_out[i] = out_valid_q;
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pending_d   = pending_q;
        sel_err_d   = sel_err_q;
        out_valid_d = out_valid_q;
        out_sel_d   = out_sel_q;
        out_data_d  = out_data_q;

        if (push_fire) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        // An out-of-range head is consumed but never presented to a lane.
        if (rsp_fire) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            out_sel_d   = head;
            out_data_d  = rsp_data_in;
            out_valid_d = head_in_range;
            if (!head_in_range) begin
                sel_err_d = 1'b1;
            end
        end else if (out_drain) begin
            out_valid_d = 1'b0;
        end

        if (push_fire && !rsp_fire) begin
            pending_d = pending_q + CNT_W'(1);
        end else if (!push_fire && rsp_fire) begin
            pending_d = pending_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pending_q   <= '0;
            sel_err_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_sel_q   <= '0;
            out_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pending_q   <= pending_d;
            sel_err_q   <= sel_err_d;
            out_valid_q <= out_valid_d;
            out_sel_q   <= out_sel_d;
            out_data_q  <= out_data_d;
        end
    end

    // Tag storage needs no reset: only entries between the pointers are read.
    always_ff @(posedge clk) begin
        if (push_fire) begin
            tag_mem_q[wr_ptr_q[AW-1:0]] <= push_sel;
        end
    end

endmodule

// File: tb/tb_stream_rsp_router.sv
// Bench for stream_rsp_router: directed vector table, hand-written corner
// sequences, and randomized traffic against a queue-based reference model.
module tb_stream_rsp_router;

    localparam int N  = 4;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;

    logic            pv;
    logic [1:0]      ps;
    logic            pr;
    logic            rv;
    logic [DW-1:0]   rd;
    logic            rri;
    logic [N-1:0]    vo;
    logic [N*DW-1:0] dout;
    logic [N-1:0]    ro;
    logic [3:0]      pend;
    logic            err;

    logic            p3_v;
    logic [1:0]      p3_s;
    logic            pr3;
    logic            r3_v;
    logic [DW-1:0]   r3_d;
    logic            rri3;
    logic [2:0]      vo3;
    logic [3*DW-1:0] do3;
    logic [2:0]      ro3;
    logic [3:0]      pend3;
    logic            err3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_rsp_router #(.NUM_INPUTS(N), .DATAW(DW), .TAG_DEPTH(8)) u_dut (
        .clk(clk), .reset(reset),
        .push_valid(pv), .push_sel(ps), .push_ready(pr),
        .rsp_valid_in(rv), .rsp_data_in(rd), .rsp_ready_in(rri),
        .rsp_valid_out(vo), .rsp_data_out(dout), .rsp_ready_out(ro),
        .pending(pend), .sel_err(err)
    );

    stream_rsp_router #(.NUM_INPUTS(3), .DATAW(DW), .TAG_DEPTH(8)) u_dut3 (
        .clk(clk), .reset(reset),
        .push_valid(p3_v), .push_sel(p3_s), .push_ready(pr3),
        .rsp_valid_in(r3_v), .rsp_data_in(r3_d), .rsp_ready_in(rri3),
        .rsp_valid_out(vo3), .rsp_data_out(do3), .rsp_ready_out(ro3),
        .pending(pend3), .sel_err(err3)
    );

    typedef struct {
        logic          pv;
        logic [1:0]    ps;
        logic          rv;
        logic [DW-1:0] rd;
        logic [N-1:0]  ro;
        logic          e_pr;
        logic          e_rri;
        logic [N-1:0]  e_vo;
        logic [DW-1:0] e_data;
        logic [3:0]    e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic p_v, logic [1:0] p_s, logic r_v, logic [DW-1:0] r_d,
                                logic [N-1:0] r_o, logic e_pr, logic e_rri,
                                logic [N-1:0] e_vo, logic [DW-1:0] e_data, logic [3:0] e_pend);
        vec_t v;
        v.pv = p_v; v.ps = p_s; v.rv = r_v; v.rd = r_d; v.ro = r_o;
        v.e_pr = e_pr; v.e_rri = e_rri; v.e_vo = e_vo; v.e_data = e_data; v.e_pend = e_pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        pv = 1'b0; ps = '0; rv = 1'b0; rd = '0; ro = '1;
        p3_v = 1'b0; p3_s = '0; r3_v = 1'b0; r3_d = '0; ro3 = '1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Reference model state
    int            tagq[$];
    bit            m_has;
    int            m_sel;
    logic [DW-1:0] m_data;

    localparam logic [DW-1:0] D0 = 32'hA000_0000, D1 = 32'hA111_1111,
                              D2 = 32'hA222_2222, D3 = 32'hA333_3333,
                              DA = 32'hBEEF_000A, DB = 32'hBEEF_000B,
                              DC = 32'hC0DE_000C, Z  = 32'h0;

    initial begin
        idle_inputs();
        reset = 1'b0;
        #1;
        chk("rst_push_ready", 128'(pr), 128'(1));
        chk("rst_rsp_ready_in", 128'(rri), 128'(0));
        chk("rst_valid_out", 128'(vo), 128'(0));
        chk("rst_data_out", 128'(dout), 128'(0));
        @(negedge clk);
        tick();
        reset = 1'b1;

        // Ordered routing, back-pressure hold, and empty-FIFO push/rsp collision.
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(1, 2, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(1, 0, 0, Z,  4'hF, 1, 1, 4'b0000, Z,  1));
        vecs.push_back(mk(1, 3, 0, Z,  4'hF, 1, 1, 4'b0000, Z,  2));
        vecs.push_back(mk(1, 1, 0, Z,  4'hF, 1, 1, 4'b0000, Z,  3));
        vecs.push_back(mk(0, 0, 1, D0, 4'hF, 1, 1, 4'b0000, Z,  4));
        vecs.push_back(mk(0, 0, 1, D1, 4'hF, 1, 1, 4'b0100, D0, 3));
        vecs.push_back(mk(0, 0, 1, D2, 4'hF, 1, 1, 4'b0001, D1, 2));
        vecs.push_back(mk(0, 0, 1, D3, 4'hF, 1, 1, 4'b1000, D2, 1));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0010, D3, 0));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(1, 1, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(1, 1, 0, Z,  4'hF, 1, 1, 4'b0000, Z,  1));
        vecs.push_back(mk(0, 0, 1, DA, 4'hD, 1, 1, 4'b0000, Z,  2));
        vecs.push_back(mk(0, 0, 1, DB, 4'hD, 1, 0, 4'b0010, DA, 1));
        vecs.push_back(mk(0, 0, 1, DB, 4'hD, 1, 0, 4'b0010, DA, 1));
        vecs.push_back(mk(0, 0, 1, DB, 4'hD, 1, 0, 4'b0010, DA, 1));
        vecs.push_back(mk(0, 0, 1, DB, 4'hF, 1, 1, 4'b0010, DA, 1));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0010, DB, 0));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(1, 3, 1, DC, 4'hF, 1, 0, 4'b0000, Z,  0));
        vecs.push_back(mk(0, 0, 1, DC, 4'hF, 1, 1, 4'b0000, Z,  1));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b1000, DC, 0));
        vecs.push_back(mk(0, 0, 0, Z,  4'hF, 1, 0, 4'b0000, Z,  0));

        for (int k = 0; k < vecs.size(); k++) begin
            pv = vecs[k].pv; ps = vecs[k].ps; rv = vecs[k].rv; rd = vecs[k].rd; ro = vecs[k].ro;
            #1;
            chk($sformatf("vec%0d_push_ready", k), 128'(pr), 128'(vecs[k].e_pr));
            chk($sformatf("vec%0d_rsp_ready_in", k), 128'(rri), 128'(vecs[k].e_rri));
            chk($sformatf("vec%0d_valid_out", k), 128'(vo), 128'(vecs[k].e_vo));
            chk($sformatf("vec%0d_pending", k), 128'(pend), 128'(vecs[k].e_pend));
            if (vecs[k].e_vo != '0)
                chk($sformatf("vec%0d_data_out", k), 128'(dout), 128'({N{vecs[k].e_data}}));
            tick();
        end

        // Full FIFO: push alongside a pop is refused.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            pv = 1'b1; ps = 2'(i % 4);
            tick();
        end
        pv = 1'b0;
        #1;
        chk("full_pending", 128'(pend), 128'(8));
        chk("full_push_ready", 128'(pr), 128'(0));
        chk("full_rsp_ready_in", 128'(rri), 128'(1));
        pv = 1'b1; ps = 2'd2; rv = 1'b1; rd = 32'hF00D; ro = '1;
        #1;
        chk("full_pushpop_push_ready", 128'(pr), 128'(0));
        tick();
        pv = 1'b0; rv = 1'b0;
        #1;
        chk("full_after_pending", 128'(pend), 128'(7));
        chk("full_after_push_ready", 128'(pr), 128'(1));
        chk("full_after_valid_out", 128'(vo), 128'(4'b0001));
        chk("full_after_data", 128'(dout), 128'({N{32'hF00D}}));

        // Asynchronous reset mid-stream with a held output and pending=5.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pv = 1'b1; ps = 2'(i % 4);
            tick();
        end
        pv = 1'b0; rv = 1'b1; rd = 32'hBEEF; ro = '0;
        tick();
        rv = 1'b0;
        #1;
        chk("midrst_pre_pending", 128'(pend), 128'(5));
        chk("midrst_pre_valid_out", 128'(vo), 128'(4'b0001));
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_pending", 128'(pend), 128'(0));
        chk("midrst_push_ready", 128'(pr), 128'(1));
        chk("midrst_rsp_ready_in", 128'(rri), 128'(0));
        chk("midrst_valid_out", 128'(vo), 128'(0));
        chk("midrst_data_out", 128'(dout), 128'(0));
        @(negedge clk);
        ro = '1;
        tick();
        reset = 1'b1;

        // Out-of-range select on the 3-input instance.
        p3_v = 1'b1; p3_s = 2'd3;
        tick();
        p3_s = 2'd0;
        tick();
        p3_v = 1'b0; r3_v = 1'b1; r3_d = 32'h1111_0001;
        #1;
        chk("n3_rsp_ready_first", 128'(rri3), 128'(1));
        tick();
        r3_d = 32'h2222_0002;
        #1;
        chk("n3_dropped_valid_out", 128'(vo3), 128'(0));
        chk("n3_sel_err_set", 128'(err3), 128'(1));
        chk("n3_rsp_ready_second", 128'(rri3), 128'(1));
        tick();
        r3_v = 1'b0;
        #1;
        chk("n3_lane0_valid", 128'(vo3), 128'(3'b001));
        chk("n3_lane0_data", 128'(do3), 128'({3{32'h2222_0002}}));
        chk("n3_pending", 128'(pend3), 128'(0));
        tick();
        #1;
        chk("n3_drained", 128'(vo3), 128'(0));
        chk("n3_sel_err_sticky", 128'(err3), 128'(1));

        // Randomized traffic against the queue model.
        do_reset();
        tagq.delete();
        m_has = 1'b0; m_sel = 0; m_data = '0;
        for (int c = 0; c < 600; c++) begin
            bit            e_rri, drain, fire, push;
            logic [N-1:0]  e_vo;
            pv = ($urandom_range(0, 99) < 55);
            ps = 2'($urandom_range(0, 3));
            rv = ($urandom_range(0, 99) < 65);
            rd = $urandom;
            ro = ($urandom_range(0, 99) < 50) ? 4'hF : 4'($urandom_range(0, 15));
            #1;
            drain = m_has && ro[m_sel];
            e_rri = (tagq.size() > 0) && (!m_has || drain);
            e_vo  = m_has ? 4'(1 << m_sel) : 4'b0;
            chk($sformatf("rnd%0d_pending", c), 128'(pend), 128'(tagq.size()));
            chk($sformatf("rnd%0d_push_ready", c), 128'(pr), 128'(tagq.size() < 8));
            chk($sformatf("rnd%0d_rsp_ready_in", c), 128'(rri), 128'(e_rri));
            chk($sformatf("rnd%0d_valid_out", c), 128'(vo), 128'(e_vo));
            chk($sformatf("rnd%0d_data_out", c), 128'(dout), 128'({N{m_data}}));
            chk($sformatf("rnd%0d_sel_err", c), 128'(err), 128'(0));
            fire = rv && e_rri;
            push = pv && (tagq.size() < 8);
            if (fire) begin
                m_sel  = tagq.pop_front();
                m_data = rd;
                m_has  = 1'b1;
            end else if (drain) begin
                m_has = 1'b0;
            end
            if (push) tagq.push_back(int'(ps));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
